// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1x16 demux dispatcher.
// State encoding, channel count and one-hot decode.
package demux_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        SEND   = 2'd2
    } state_t;

    function automatic logic [N_CH-1:0] onehot16(
        input logic [SEL_W-1:0] sel
    );
        logic [N_CH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux1x16_onehot.sv
// Gated 1x16 one-hot decode of the channel select.
// Output is all zero when the enable is low.
module demux1x16_onehot
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_en,
    output logic [N_CH-1:0]  o_vec
);

    // Decode the select only while a word is being offered
    always_comb begin
        o_vec = '0;
        if (i_en) begin
            o_vec = onehot16(i_sel);
        end
    end

endmodule

// File: rtl/demux1x16_dispatcher.sv
// Round-robin dispatcher: one input stream fanned out to 16
// channels, scanning one channel per cycle from the last served.
module demux1x16_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]   ch_en,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              drop
);

    state_t              r_state;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_skip;
    logic [DATA_W-1:0]   r_hold;

    state_t              w_state_nx;
    logic [SEL_W-1:0]    w_ptr_nx;
    logic [SEL_W-1:0]    w_skip_nx;
    logic [DATA_W-1:0]   w_hold_nx;
    logic                w_in_ready;
    logic                w_drop;
    logic                w_send;

    // State, pointer, skip counter and holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_skip  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_skip  <= w_skip_nx;
            r_hold  <= w_hold_nx;
        end
    end

    // Next-state logic: accept, scan one channel per cycle, offer
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_skip_nx  = r_skip;
        w_hold_nx  = r_hold;
        w_in_ready = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_hold_nx  = in_data;
                    w_skip_nx  = '0;
                    w_state_nx = SEARCH;
                end
            end
            SEARCH: begin
                if (ch_en[r_ptr]) begin
                    w_state_nx = SEND;
                end else begin
                    w_ptr_nx  = r_ptr + 4'd1;
                    w_skip_nx = r_skip + 4'd1;
                    // A full lap with nothing enabled: give up on the word
                    if (r_skip == 4'd15) begin
                        w_drop     = 1'b1;
                        w_hold_nx  = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
            SEND: begin
                // Held until the consumer takes it, even if disabled
                if (out_ready[r_ptr]) begin
                    w_ptr_nx   = r_ptr + 4'd1;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign w_send   = (r_state == SEND);
    assign in_ready = w_in_ready;
    assign drop     = w_drop;
    assign busy     = (r_state != IDLE);
    assign sel      = r_ptr;
    assign out_data = r_hold;

    demux1x16_onehot u_onehot (
        .i_sel (r_ptr),
        .i_en  (w_send),
        .o_vec (out_valid)
    );

endmodule

// File: tb/tb_demux1x16_dispatcher.sv
// Directed bench for demux1x16_dispatcher: vector table
// for round-robin plus hand-written multi-cycle sequences.
module tb_demux1x16_dispatcher;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [15:0] ch_en;
    logic [15:0] out_valid;
    logic [15:0] out_ready;
    logic [7:0]  out_data;
    logic [3:0]  sel;
    logic        busy;
    logic        drop;

    int n_pass;
    int n_total;

    demux1x16_dispatcher #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  din;
        logic [15:0] ov;
        logic [3:0]  sel;
        logic        ir;
        logic        busy;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [7:0] din,
                                input logic [15:0] ov, input logic [3:0] s,
                                input logic ir, input logic b,
                                input logic [7:0] dout);
        vec_t v;
        v.iv = iv; v.din = din; v.ov = ov; v.sel = s;
        v.ir = ir; v.busy = b; v.dout = dout;
        return v;
    endfunction

    // Starts just after a posedge in IDLE; ends at the negedge of the
    // first cycle with out_valid set. idx counts cycles with the
    // acceptance cycle as 0; -1 if out_valid never rose.
    task automatic accept_wait(input logic [7:0] d, input int maxc,
                               output int idx);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idx = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (out_valid != 16'h0) begin
                idx = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int idx;
        int drops;
        int drop_idx;
        int ov_bad;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ch_en     = 16'hFFFF;
        out_ready = 16'hFFFF;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic round-robin: A0..A3 to ch0..ch3, all enabled/ready
        for (int w = 0; w < 4; w++) begin
            tbl[3*w]   = mk(1'b1, 8'(8'hA0 + w), 16'h0, 4'(w),
                            1'b1, 1'b0, 8'h00);
            tbl[3*w+1] = mk(1'b1, 8'(8'hA1 + w), 16'h0, 4'(w),
                            1'b0, 1'b1, 8'h00);
            tbl[3*w+2] = mk(1'b1, 8'(8'hA1 + w), 16'(1 << w), 4'(w),
                            1'b0, 1'b1, 8'(8'hA0 + w));
        end
        tbl[12] = mk(1'b0, 8'h00, 16'h0, 4'd4, 1'b1, 1'b0, 8'h00);

        for (int r = 0; r < 13; r++) begin
            in_valid = tbl[r].iv;
            in_data  = tbl[r].din;
            @(negedge clk);
            chk($sformatf("rr%0d_out_valid", r), 32'(out_valid),
                32'(tbl[r].ov));
            chk($sformatf("rr%0d_sel", r), 32'(sel), 32'(tbl[r].sel));
            chk($sformatf("rr%0d_in_ready", r), 32'(in_ready),
                32'(tbl[r].ir));
            chk($sformatf("rr%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            chk($sformatf("rr%0d_drop", r), 32'(drop), 32'd0);
            if (tbl[r].ov != 16'h0) begin
                chk($sformatf("rr%0d_data", r), 32'(out_data),
                    32'(tbl[r].dout));
            end
            @(posedge clk); #1;
        end

        // Move ptr to 14: only ch13 enabled, scan 4..13
        ch_en = 16'h2000;
        accept_wait(8'h11, 40, idx);
        chk("pre_wrap_latency", 32'(idx), 32'd11);
        chk("pre_wrap_out_valid", 32'(out_valid), 32'h2000);
        @(posedge clk); #1;

        // Wrap: visit 14, 15, then send on ch0
        ch_en = 16'h0003;
        accept_wait(8'hB0, 40, idx);
        chk("wrap_latency", 32'(idx), 32'd4);
        chk("wrap_out_valid", 32'(out_valid), 32'h0001);
        chk("wrap_sel", 32'(sel), 32'd0);
        chk("wrap_data", 32'(out_data), 32'hB0);
        @(posedge clk); #1;
        accept_wait(8'hB1, 40, idx);
        chk("wrap_next_latency", 32'(idx), 32'd2);
        chk("wrap_next_out_valid", 32'(out_valid), 32'h0002);
        chk("wrap_next_data", 32'(out_data), 32'hB1);
        @(posedge clk); #1;

        // Back-pressure on ch4; other channels ready but ignored
        ch_en     = 16'h0010;
        out_ready = 16'hFFEF;
        accept_wait(8'hC3, 40, idx);
        chk("bp_latency", 32'(idx), 32'd4);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("bp%0d_out_valid", s), 32'(out_valid),
                32'h0010);
            chk($sformatf("bp%0d_in_ready", s), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_data", s), 32'(out_data), 32'hC3);
            @(posedge clk); #1;
            if (s == 1) ch_en = 16'h0000;
            @(negedge clk);
        end
        out_ready = 16'h0010;
        chk("bp_final_out_valid", 32'(out_valid), 32'h0010);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_sel", 32'(sel), 32'd5);
        chk("bp_after_in_ready", 32'(in_ready), 32'd1);
        chk("bp_after_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // No enabled channel: drop after a full lap
        ch_en     = 16'h0000;
        out_ready = 16'hFFFF;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        @(negedge clk);
        chk("drop_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drops    = 0;
        drop_idx = -1;
        ov_bad   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid != 16'h0) ov_bad++;
            if (drop) begin
                drops++;
                if (drop_idx < 0) drop_idx = i;
            end
            @(posedge clk); #1;
        end
        chk("drop_count", 32'(drops), 32'd1);
        chk("drop_cycle", 32'(drop_idx), 32'd16);
        chk("drop_out_valid_zero", 32'(ov_bad), 32'd0);
        @(negedge clk);
        chk("drop_after_in_ready", 32'(in_ready), 32'd1);
        chk("drop_after_busy", 32'(busy), 32'd0);
        chk("drop_after_sel", 32'(sel), 32'd5);
        @(posedge clk); #1;

        // Reset while offering on ch8
        ch_en     = 16'h0100;
        out_ready = 16'h0000;
        accept_wait(8'hE7, 40, idx);
        chk("rsend_latency", 32'(idx), 32'd5);
        chk("rsend_out_valid", 32'(out_valid), 32'h0100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rsend_out_valid_clr", 32'(out_valid), 32'h0);
        chk("rsend_sel", 32'(sel), 32'd0);
        chk("rsend_busy", 32'(busy), 32'd0);
        chk("rsend_in_ready", 32'(in_ready), 32'd1);
        chk("rsend_drop", 32'(drop), 32'd0);
        @(posedge clk); #1;
        ch_en     = 16'hFFFF;
        out_ready = 16'hFFFF;
        accept_wait(8'h3C, 40, idx);
        chk("rsend_next_latency", 32'(idx), 32'd2);
        chk("rsend_next_out_valid", 32'(out_valid), 32'h0001);
        chk("rsend_next_data", 32'(out_data), 32'h3C);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
